decode_fwd_scoreboard: RTL and testbench
========================================

Name: decode_fwd_scoreboard

Overview:
- Parametrised decode-stage operand forwarding and load-use interlock unit.
- Keeps its own in-flight destination tracker, a shift register of producer entries, one per downstream stage (stage 0 = EX).
- Selects the youngest matching stage result for each source operand.
- Stalls decode when the youngest matching producer's data is not ready, for example a load not yet at its data-ready stage.
- Sits between the register file read ports and the ID/EX pipeline register; supports any number of stages, source operands, and load latency.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- RF_ADDR_WIDTH, 5, register address width.
- NUM_SRC, 2, number of source operands per decoded instruction.
- NUM_STAGES, 3, tracked downstream stages (EX, MEM, WB).
- LD_READY_STAGE, 1, lowest stage index whose stage_data_i carries valid load data; must be < NUM_STAGES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- issue_valid_i  in  1  decode holds a valid instruction.
- issue_rd_i  in  RF_ADDR_WIDTH  destination register of the decoding instruction.
- issue_wen_i  in  1  decoding instruction writes rd.
- issue_ld_i  in  1  decoding instruction is a load.
- src_addr_i  in  NUM_SRC*RF_ADDR_WIDTH  source addresses; operand k is bits [k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH].
- src_used_i  in  NUM_SRC  operand k is actually read.
- rf_data_i  in  NUM_SRC*DATA_WIDTH  register file read data.
- stage_data_i  in  NUM_STAGES*DATA_WIDTH  result of each stage (stage s at [s*DATA_WIDTH +: DATA_WIDTH]).
- hold_i  in  1  global pipeline freeze (e.g. cache miss).
- flush_i  in  1  squash the decoding instruction.
- src_data_o  out  NUM_SRC*DATA_WIDTH  forwarded operand data.
- fwd_hit_o  out  NUM_SRC  operand k taken from a stage rather than the RF.
- stall_o  out  1  load-use / not-ready interlock request.
- stage_vld_o  out  NUM_STAGES  tracker entry valid and writing (debug/visibility).

Behaviour:
- Tracker entry fields: {vld, rd, wen, ld}.
  - Entry s is "producing" when vld && wen && rd != 0.
  - Entry s is "ready" when !ld || s >= LD_READY_STAGE.
- Operand k, combinational:
  - If !src_used_i[k] or addr == 0: data = rf_data, hit = 0, no stall contribution.
  - Otherwise find the lowest s whose producing entry has rd == addr (youngest wins).
  - If that s exists: data = stage_data_i[s], hit = 1; if the entry is not ready, operand k requests a stall.
  - If no s matches: data = rf_data, hit = 0.
- stall_o = issue_valid_i && OR of per-operand stall requests.
- Update at posedge clk:
  - rst: all entries vld = 0; the counters, when present, are cleared. Reset mid-operation discards the whole tracker in one cycle.
  - hold_i = 1: tracker frozen, including when flush_i or stall_o are also high (hold dominates).
  - Otherwise: entry s moves to s+1 and the last entry is dropped.
  - Stage 0 loads {1, issue_rd_i, issue_wen_i, issue_ld_i} when issue_valid_i && !stall_o && !flush_i; otherwise it loads a bubble (vld = 0).
- Outputs after reset: stall_o = 0, fwd_hit_o = 0, stage_vld_o = 0, src_data_o = rf_data_i.
- Latency:
  - Forward path is zero-cycle combinational from the current tracker state.
  - Tracker reflects an issued instruction starting the cycle after it leaves decode.
- A load stalls its dependent for exactly LD_READY_STAGE cycles when no hold intervenes.
- Same rd in several entries: only the youngest is considered; an older ready copy never overrides a younger non-ready one.
- NUM_SRC operands are independent; both may match the same or different stages.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cnt_o (out, 32): increments each cycle stall_o && !hold_i.
  - fwd_cnt_o (out, 32): increments each non-hold, non-stall cycle with issue_valid_i and any fwd_hit_o bit set.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, neither port nor counter logic exists, and the block's behaviour is otherwise identical.

Test Plan:
- ALU-to-ALU forwarding:
  - Stimulus: issue add x5 (wen = 1, ld = 0). Next cycle, decode src0 = x5 with stage_data_i[0] = 32'h1234.
  - Required: src_data_o[0] = 32'h1234, fwd_hit_o = 2'b01, stall_o = 0.
- Load-use, defaults:
  - Stimulus: issue lw x7, then decode reads x7.
  - Required: stall_o = 1 for 1 cycle. Next cycle src_data_o = stage_data_i[1] = 32'hDEAD_BEEF, stall_o = 0. Stage 0 held a bubble during the stall.
- LD_READY_STAGE = 2:
  - Stimulus: same load-use sequence.
  - Required: exactly 2 stall cycles, then data taken from stage 2.
- Priority and x0:
  - Stimulus: x3 in flight at stages 0 and 2 with data 32'hA and 32'hB; src1 = x0 with rf_data 32'h0.
  - Required: src0 = 32'hA; src1 = 0 with hit = 0; a pending load to x0 causes no stall.
- Hold and flush:
  - Stimulus: hold_i = 1 for 3 cycles with a load in stage 0.
  - Required: stage_vld_o unchanged and stall_o stays 1.
  - Stimulus: flush_i with a valid issue.
  - Required: a bubble enters stage 0; a subsequent reader of that rd takes RF data.
- Reset mid-stream:
  - Stimulus: assert rst with 3 valid entries.
  - Required: next cycle stage_vld_o = 0, stall_o = 0, counters = 0 (with FWD_PERF_CNT_EN).
  - Stimulus: run 2^32 stall cycles (forced).
  - Required: stall_cnt_o saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/decode_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_fwd_scoreboard
// Description : Decode-stage operand forwarding and load-use interlock with an
//               in-flight destination tracker. Optional perf counters are
//               enabled by defining FWD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_fwd_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int RF_ADDR_WIDTH  = 5,
    parameter int NUM_SRC        = 2,
    parameter int NUM_STAGES     = 3,
    parameter int LD_READY_STAGE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid_i,
    input  logic [RF_ADDR_WIDTH-1:0]         issue_rd_i,
    input  logic                             issue_wen_i,
    input  logic                             issue_ld_i,
    input  logic [NUM_SRC*RF_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]               src_used_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    rf_data_i,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data_i,
    input  logic                             hold_i,
    input  logic                             flush_i,
    output logic [NUM_SRC*DATA_WIDTH-1:0]    src_data_o,
    output logic [NUM_SRC-1:0]               fwd_hit_o,
    output logic                             stall_o,
    output logic [NUM_STAGES-1:0]            stage_vld_o
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                      stall_cnt_o,
    output logic [31:0]                      fwd_cnt_o
`endif
);

    localparam int AW = RF_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [NUM_STAGES-1:0]    vld_q, vld_d, wen_q, wen_d, ld_q, ld_d;
    logic [NUM_STAGES*AW-1:0] rd_q, rd_d;
    logic [NUM_STAGES-1:0]    producing;
    logic [NUM_STAGES-1:0]    ready;
    logic [NUM_SRC-1:0]       src_stall;
    logic                     issue_go;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        assign producing[s]   = vld_q[s] && wen_q[s] && (rd_q[s*AW +: AW] != '0);
        assign stage_vld_o[s] = vld_q[s] && wen_q[s];
        if (s >= LD_READY_STAGE) begin : g_late
            assign ready[s] = 1'b1;
        end else begin : g_early
            assign ready[s] = !ld_q[s];
        end
    end

    // Oldest-to-youngest scan so the youngest matching producer wins.
    always_comb begin
        src_data_o = rf_data_i;
        fwd_hit_o  = '0;
        src_stall  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_used_i[k] && (src_addr_i[k*AW +: AW] != '0)) begin
                for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                    if (producing[s] && (rd_q[s*AW +: AW] == src_addr_i[k*AW +: AW])) begin
                        src_data_o[k*DW +: DW] = stage_data_i[s*DW +: DW];
                        fwd_hit_o[k]           = 1'b1;
                        src_stall[k]           = !ready[s];
                    end
                end
            end
        end
    end

    assign stall_o  = issue_valid_i && (|src_stall);
    assign issue_go = issue_valid_i && !stall_o && !flush_i;

    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        wen_d = wen_q;
        ld_d  = ld_q;
        if (!hold_i) begin
            for (int s = NUM_STAGES - 1; s > 0; s--) begin
                vld_d[s]          = vld_q[s-1];
                rd_d[s*AW +: AW]  = rd_q[(s-1)*AW +: AW];
                wen_d[s]          = wen_q[s-1];
                ld_d[s]           = ld_q[s-1];
            end
            vld_d[0]    = issue_go;
            rd_d[AW-1:0] = issue_rd_i;
            wen_d[0]    = issue_wen_i;
            ld_d[0]     = issue_ld_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
            wen_q <= '0;
            ld_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            wen_q <= wen_d;
            ld_q  <= ld_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_o && !hold_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!hold_i && !stall_o && issue_valid_i && (|fwd_hit_o) &&
                (fwd_cnt_q != 32'hFFFF_FFFF)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_fwd_scoreboard
// Description : Directed vector table, load-latency sequence and randomized
//               run against a reference model, for LD_READY_STAGE 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_fwd_scoreboard;

    localparam int NS    = 3;
    localparam int LRS_A = 1;
    localparam int LRS_B = 2;
    localparam logic [31:0] RF0 = 32'h0000_0F00;
    localparam logic [31:0] RF1 = 32'h0000_0F01;
    localparam logic [31:0] SD0 = 32'h5555_0000;
    localparam logic [31:0] SD1 = 32'hDEAD_BEEF;
    localparam logic [31:0] SD2 = 32'h2222_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wen, issue_ld, hold, flush;
    logic [4:0]  issue_rd;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic [63:0] rf_data;
    logic [95:0] stage_data;

    logic [63:0] a_data, b_data;
    logic [1:0]  a_hit, b_hit;
    logic        a_stall, b_stall;
    logic [2:0]  a_sv, b_sv;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_fwd_scoreboard #(.LD_READY_STAGE(LRS_A)) dut_a (
        .clk(clk), .rst(rst), .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .issue_wen_i(issue_wen), .issue_ld_i(issue_ld), .src_addr_i(src_addr),
        .src_used_i(src_used), .rf_data_i(rf_data), .stage_data_i(stage_data),
        .hold_i(hold), .flush_i(flush), .src_data_o(a_data), .fwd_hit_o(a_hit),
        .stall_o(a_stall), .stage_vld_o(a_sv)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt_o(a_scnt), .fwd_cnt_o(a_fcnt)
`endif
    );

    decode_fwd_scoreboard #(.LD_READY_STAGE(LRS_B)) dut_b (
        .clk(clk), .rst(rst), .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .issue_wen_i(issue_wen), .issue_ld_i(issue_ld), .src_addr_i(src_addr),
        .src_used_i(src_used), .rf_data_i(rf_data), .stage_data_i(stage_data),
        .hold_i(hold), .flush_i(flush), .src_data_o(b_data), .fwd_hit_o(b_hit),
        .stall_o(b_stall), .stage_vld_o(b_sv)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt_o(b_scnt), .fwd_cnt_o(b_fcnt)
`endif
    );

    // Reference model: per instance, the record that left decode in each of
    // the last NS non-hold cycles (index 0 = most recent).
    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } entry_t;

    entry_t      mt [2][NS];
    logic [31:0] mc_stall [2];
    logic [31:0] mc_fwd   [2];

    function automatic void meval(input int i, output logic st, output logic [1:0] hit,
                                  output logic [63:0] dat, output logic [2:0] sv);
        logic [4:0] a;
        logic [1:0] req;
        bit         found;
        int         lrs;
        lrs = (i == 0) ? LRS_A : LRS_B;
        req = '0;
        hit = '0;
        dat = rf_data;
        for (int k = 0; k < 2; k++) begin
            a = src_addr[k*5 +: 5];
            found = 0;
            if (src_used[k] && a != 5'd0) begin
                for (int s = 0; s < NS; s++) begin
                    if (!found && mt[i][s].vld && mt[i][s].wen && mt[i][s].rd == a) begin
                        found = 1;
                        hit[k] = 1'b1;
                        dat[k*32 +: 32] = stage_data[s*32 +: 32];
                        req[k] = mt[i][s].ld && (s < lrs);
                    end
                end
            end
        end
        st = issue_valid && (|req);
        for (int s = 0; s < NS; s++) sv[s] = mt[i][s].vld && mt[i][s].wen;
    endfunction

    task automatic model_update();
        logic st; logic [1:0] h; logic [63:0] d; logic [2:0] sv;
        for (int i = 0; i < 2; i++) begin
            meval(i, st, h, d, sv);
            if (rst) begin
                for (int s = 0; s < NS; s++) mt[i][s] = '0;
                mc_stall[i] = '0;
                mc_fwd[i]   = '0;
            end else if (!hold) begin
                if (st && mc_stall[i] != 32'hFFFF_FFFF) mc_stall[i] = mc_stall[i] + 1;
                if (!st && issue_valid && (|h) && mc_fwd[i] != 32'hFFFF_FFFF)
                    mc_fwd[i] = mc_fwd[i] + 1;
                for (int s = NS - 1; s > 0; s--) mt[i][s] = mt[i][s-1];
                mt[i][0] = (issue_valid && !st && !flush) ?
                           {1'b1, issue_rd, issue_wen, issue_ld} : '0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_wen = 0; issue_ld = 0;
        src_addr = 0; src_used = 0; hold = 0; flush = 0;
        rf_data = {RF1, RF0}; stage_data = {SD2, SD1, SD0};
    endtask

    task automatic next_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1;
        idle_inputs();
        next_cycle();
        rst = 0;
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] rd, input logic w,
                               input logic l, input logic [4:0] a0, input logic [1:0] u);
        issue_valid = v; issue_rd = rd; issue_wen = w; issue_ld = l;
        src_addr = {5'd0, a0}; src_used = u;
    endtask

    typedef struct {
        logic v; logic [4:0] rd; logic wen, ld;
        logic [4:0] a0, a1; logic [1:0] used; logic hold, flush;
        logic [31:0] sd0, sd2, rf1;
        logic stall; logic [1:0] hit; logic [31:0] d0, d1; logic [2:0] sv;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mkv(logic v, logic [4:0] rd, logic w, logic l, logic [4:0] a0,
                                 logic [4:0] a1, logic [1:0] u, logic h, logic f,
                                 logic [31:0] s0, logic [31:0] s2, logic [31:0] r1,
                                 logic st, logic [1:0] hit, logic [31:0] d0,
                                 logic [31:0] d1, logic [2:0] sv);
        vec_t r;
        r.v = v; r.rd = rd; r.wen = w; r.ld = l; r.a0 = a0; r.a1 = a1; r.used = u;
        r.hold = h; r.flush = f; r.sd0 = s0; r.sd2 = s2; r.rf1 = r1;
        r.stall = st; r.hit = hit; r.d0 = d0; r.d1 = d1; r.sv = sv;
        return r;
    endfunction

    initial begin
        logic st; logic [1:0] h; logic [63:0] d; logic [2:0] sv;
        int nst;
        bit done;

        // ALU forward, load-use, x0/priority, flush, then hold on a pending load.
        tbl[0]  = mkv(1, 5, 1, 0, 0, 0, 2'b00, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b000);
        tbl[1]  = mkv(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 32'h1234, SD2, RF1,
                      0, 2'b01, 32'h1234, RF1, 3'b001);
        tbl[2]  = mkv(1, 7, 1, 1, 0, 0, 2'b00, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b010);
        tbl[3]  = mkv(1, 0, 0, 0, 7, 0, 2'b01, 0, 0, SD0, SD2, RF1, 1, 2'b01, SD0, RF1, 3'b101);
        tbl[4]  = mkv(1, 0, 0, 0, 7, 0, 2'b01, 0, 0, SD0, SD2, RF1, 0, 2'b01, SD1, RF1, 3'b010);
        tbl[5]  = mkv(1, 3, 1, 0, 0, 0, 2'b00, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b100);
        tbl[6]  = mkv(1, 0, 1, 1, 0, 0, 2'b00, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b001);
        tbl[7]  = mkv(1, 3, 1, 0, 0, 0, 2'b01, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b011);
        tbl[8]  = mkv(1, 0, 0, 0, 3, 0, 2'b11, 0, 0, 32'hA, 32'hB, 32'h0,
                      0, 2'b01, 32'hA, 32'h0, 3'b111);
        tbl[9]  = mkv(1, 9, 1, 0, 0, 0, 2'b00, 0, 1, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b110);
        tbl[10] = mkv(1, 0, 0, 0, 9, 0, 2'b01, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b100);
        tbl[11] = mkv(1, 12, 1, 1, 0, 0, 2'b00, 0, 0, SD0, SD2, RF1, 0, 2'b00, RF0, RF1, 3'b000);
        tbl[12] = mkv(1, 0, 0, 0, 12, 0, 2'b01, 1, 0, SD0, SD2, RF1, 1, 2'b01, SD0, RF1, 3'b001);
        tbl[13] = mkv(1, 0, 0, 0, 12, 0, 2'b01, 1, 1, SD0, SD2, RF1, 1, 2'b01, SD0, RF1, 3'b001);
        tbl[14] = mkv(1, 0, 0, 0, 12, 0, 2'b01, 1, 0, SD0, SD2, RF1, 1, 2'b01, SD0, RF1, 3'b001);
        tbl[15] = mkv(1, 0, 0, 0, 12, 0, 2'b01, 0, 0, SD0, SD2, RF1, 1, 2'b01, SD0, RF1, 3'b001);
        tbl[16] = mkv(1, 0, 0, 0, 12, 0, 2'b01, 0, 0, SD0, SD2, RF1, 0, 2'b01, SD1, RF1, 3'b010);

        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        apply_reset();

        for (int i = 0; i < 17; i++) begin
            issue_valid = tbl[i].v; issue_rd = tbl[i].rd;
            issue_wen = tbl[i].wen; issue_ld = tbl[i].ld;
            src_addr = {tbl[i].a1, tbl[i].a0}; src_used = tbl[i].used;
            hold = tbl[i].hold; flush = tbl[i].flush;
            stage_data = {tbl[i].sd2, SD1, tbl[i].sd0};
            rf_data = {tbl[i].rf1, RF0};
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 64'(a_stall), 64'(tbl[i].stall));
            check($sformatf("vec%0d_hit", i), 64'(a_hit), 64'(tbl[i].hit));
            check($sformatf("vec%0d_data0", i), 64'(a_data[31:0]), 64'(tbl[i].d0));
            check($sformatf("vec%0d_data1", i), 64'(a_data[63:32]), 64'(tbl[i].d1));
            check($sformatf("vec%0d_stage_vld", i), 64'(a_sv), 64'(tbl[i].sv));
            next_cycle();
        end

        // Load-use with load data ready only at stage 2.
        apply_reset();
`ifdef FWD_PERF_CNT_EN
        force dut_b.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut_b.stall_cnt_q;
        mc_stall[1] = 32'hFFFF_FFFE;
`endif
        drive_issue(1, 7, 1, 1, 0, 2'b00);
        @(negedge clk);
        next_cycle();
        drive_issue(1, 0, 0, 0, 7, 2'b01);
        nst = 0;
        done = 0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (b_stall) begin
                nst++;
                next_cycle();
            end else begin
                done = 1;
            end
        end
        check("ld2_stall_cycles", 64'(nst), 64'd2);
        check("ld2_data", 64'(b_data[31:0]), 64'(SD2));
        check("ld2_hit", 64'(b_hit), 64'd1);
        check("ld2_stage_vld", 64'(b_sv), 64'b100);
`ifdef FWD_PERF_CNT_EN
        check("ld2_stall_cnt_sat", 64'(b_scnt), 64'hFFFF_FFFF);
`endif
        next_cycle();

        // Randomized run against the model, both load latencies.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_wen   = ($urandom_range(0, 3) != 0);
            issue_ld    = ($urandom_range(0, 2) == 0);
            src_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_used    = 2'($urandom_range(0, 3));
            hold        = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            rf_data     = {$urandom, $urandom};
            stage_data  = {$urandom, $urandom, $urandom};
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                meval(i, st, h, d, sv);
                check($sformatf("rnd%0d_i%0d_stall", c, i), 64'(i == 0 ? a_stall : b_stall), 64'(st));
                check($sformatf("rnd%0d_i%0d_hit", c, i), 64'(i == 0 ? a_hit : b_hit), 64'(h));
                check($sformatf("rnd%0d_i%0d_data", c, i), i == 0 ? a_data : b_data, d);
                check($sformatf("rnd%0d_i%0d_stage_vld", c, i), 64'(i == 0 ? a_sv : b_sv), 64'(sv));
`ifdef FWD_PERF_CNT_EN
                check($sformatf("rnd%0d_i%0d_stall_cnt", c, i),
                      64'(i == 0 ? a_scnt : b_scnt), 64'(mc_stall[i]));
                check($sformatf("rnd%0d_i%0d_fwd_cnt", c, i),
                      64'(i == 0 ? a_fcnt : b_fcnt), 64'(mc_fwd[i]));
`endif
            end
            next_cycle();
        end

        // Reset with a full tracker and a stalled reader in decode.
        idle_inputs();
        drive_issue(1, 1, 1, 0, 0, 2'b00);
        next_cycle();
        drive_issue(1, 2, 1, 0, 0, 2'b00);
        next_cycle();
        drive_issue(1, 4, 1, 1, 0, 2'b00);
        next_cycle();
        drive_issue(1, 0, 0, 0, 4, 2'b01);
        @(negedge clk);
        check("pre_rst_stall", 64'(a_stall), 64'd1);
        check("pre_rst_stage_vld", 64'(a_sv), 64'b111);
        rst = 1;
        next_cycle();
        @(negedge clk);
        check("rst_stage_vld_a", 64'(a_sv), 64'd0);
        check("rst_stage_vld_b", 64'(b_sv), 64'd0);
        check("rst_stall_a", 64'(a_stall), 64'd0);
        check("rst_hit_a", 64'(a_hit), 64'd0);
        check("rst_data_a", a_data, rf_data);
`ifdef FWD_PERF_CNT_EN
        check("rst_stall_cnt", 64'(a_scnt), 64'd0);
        check("rst_fwd_cnt", 64'(a_fcnt), 64'd0);
`endif
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
